inst_axi_rd_bridge: RTL and testbench

Read-only bridge between the IF stage's instruction-SRAM-like port (req / addr_ok / data_ok) and an AXI3/AXI4 read channel pair (AR/R). It sits directly upstream of the IF stage: it accepts fetch requests, issues single-beat AXI reads, and returns in-order instruction words as one-cycle `data_ok` pulses. Up to `MAX_OUTSTANDING` fetches may be in flight, which lets the IF stage overlap the next request with the current response.

---
 rtl/inst_axi_rd_bridge_pkg.sv | 21 ++
 rtl/inst_axi_rd_bridge_rd_resp_reg.sv | 37 +++
 rtl/inst_axi_rd_bridge.sv | 118 +++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI read-side constants, size encoding and AR FSM state.
// Used by the instruction bridge and the future data-side bridge.
package inst_axi_rd_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_e;

  function automatic logic [2:0] axi_size(input logic [1:0] sz);
    return {1'b0, sz};
  endfunction

endpackage

// File: rtl/inst_axi_rd_bridge_rd_resp_reg.sv
// Read response capture: one-cycle data_ok pulse, held rdata, error pulse.
// Ports: i_fire (R handshake), i_data/i_resp (beat), o_data_ok/o_rdata/o_err.
module rd_resp_reg
  import inst_axi_rd_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_fire,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_resp,
  output logic        o_data_ok,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic        r_data_ok;
  logic [31:0] r_rdata;
  logic        r_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_data_ok <= i_fire;
      // error only accompanies the data_ok pulse
      r_err     <= i_fire && (i_resp != AXI_RESP_OKAY);
      if (i_fire) r_rdata <= i_data;
    end
  end

  assign o_data_ok = r_data_ok;
  assign o_rdata   = r_rdata;
  assign o_err     = r_err;

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// IF-stage SRAM-like fetch port to single-beat AXI AR/R read bridge.
// Ports: inst_sram_* (fetch side), inst_rd_err, ar*/r* (AXI read master).
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID_VAL        = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_rd_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  ar_state_e   r_state;
  ar_state_e   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_araddr;
  logic [1:0]  r_size;
  logic        w_accept;
  logic        w_rfire;
  logic        w_unused;

  assign w_unused = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};

  assign inst_sram_addr_ok = inst_sram_req && !inst_sram_wr &&
                             (r_state == AR_IDLE) && (r_cnt < MAX_CNT);
  assign w_accept = inst_sram_addr_ok;
  assign rready   = (r_cnt != '0);
  assign w_rfire  = rvalid && rready;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= AR_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      AR_IDLE: if (w_accept) w_state_nxt = AR_SEND;
      AR_SEND: if (arready)  w_state_nxt = AR_IDLE;
      default: w_state_nxt = AR_IDLE;
    endcase
  end

  always_comb begin
    arvalid = (r_state == AR_SEND);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_araddr <= '0;
      r_size   <= SZ_WORD;
    end else if (w_accept) begin
      r_araddr <= inst_sram_addr;
      r_size   <= inst_sram_size;
    end
  end

  // counts IF-side accepts, not AR handshakes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (w_accept && !w_rfire) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (!w_accept && w_rfire) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign arid    = ARID_VAL;
  assign araddr  = r_araddr;
  assign arlen   = 8'd0;
  assign arsize  = axi_size(r_size);
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'h0;

  rd_resp_reg u_resp (
    .clk       (clk),
    .resetn    (resetn),
    .i_fire    (w_rfire),
    .i_data    (rdata),
    .i_resp    (rresp),
    .o_data_ok (inst_sram_data_ok),
    .o_rdata   (inst_sram_rdata),
    .o_err     (inst_rd_err)
  );

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Bench for inst_axi_rd_bridge: directed vector table then random traffic
// against a queue-based model of the fetch port and an AXI slave.
module tb_inst_axi_rd_bridge;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic        addr_ok, data_ok, rd_err;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(MAXO), .ARID_VAL(4'h0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(req), .inst_sram_wr(wr),
    .inst_sram_size(size), .inst_sram_addr(addr),
    .inst_sram_wstrb(4'h0), .inst_sram_wdata(32'h0),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok),
    .inst_sram_rdata(sram_rdata), .inst_rd_err(rd_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(4'h0), .rdata(rdata), .rresp(rresp), .rlast(1'b1),
    .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, req, wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic        ar, rv;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        e_aok, e_arv;
    logic [31:0] e_araddr;
    logic [2:0]  e_arsz;
    logic        e_rrdy, e_dok;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic rst, logic rq, logic w, logic [1:0] sz, logic [31:0] a,
    logic ar, logic rv, logic [31:0] rd, logic [1:0] rr,
    logic aok, logic arv, logic [31:0] ea, logic [2:0] es,
    logic rrdy, logic dok, logic [31:0] erd, logic err);
    vec_t v;
    v.rst = rst; v.req = rq; v.wr = w; v.sz = sz; v.addr = a;
    v.ar = ar; v.rv = rv; v.rd = rd; v.rr = rr;
    v.e_aok = aok; v.e_arv = arv; v.e_araddr = ea; v.e_arsz = es;
    v.e_rrdy = rrdy; v.e_dok = dok; v.e_rdata = erd; v.e_err = err;
    return v;
  endfunction

  typedef struct { logic [31:0] a; logic [1:0] s; } ar_t;
  typedef struct { logic [31:0] d; logic [1:0] r; int t; } beat_t;

  ar_t   ar_q[$];
  beat_t rq[$];
  int    inflight;

  initial begin
    logic m_dok, m_err, m_aok, m_rfire;
    logic [31:0] m_rdata;
    int cyc;

    resetn = 1'b0; req = 0; wr = 0; size = 2; addr = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    repeat (2) @(posedge clk);

    // single fetch
    tbl.push_back(mk(1,0,0,2,0,0,0,0,0, 0,0,0,2,0,0,0,0));
    tbl.push_back(mk(1,1,0,2,32'h1C000000,0,0,0,0, 1,0,0,2,0,0,0,0));
    tbl.push_back(mk(1,0,0,2,0,1,0,0,0, 0,1,32'h1C000000,2,1,0,0,0));
    tbl.push_back(mk(1,0,0,2,0,0,1,32'h02800C0C,0,
                     0,0,32'h1C000000,2,1,0,0,0));
    tbl.push_back(mk(1,0,0,2,0,0,0,0,0,
                     0,0,32'h1C000000,2,0,1,32'h02800C0C,0));
    // halfword fetch with SLVERR beat
    tbl.push_back(mk(1,1,0,1,32'h1C000010,0,0,0,0,
                     1,0,32'h1C000000,2,0,0,32'h02800C0C,0));
    tbl.push_back(mk(1,0,0,2,0,1,0,0,0,
                     0,1,32'h1C000010,1,1,0,32'h02800C0C,0));
    tbl.push_back(mk(1,0,0,2,0,0,1,32'hDEADBEEF,2,
                     0,0,32'h1C000010,1,1,0,32'h02800C0C,0));
    tbl.push_back(mk(1,0,0,2,0,0,0,0,0,
                     0,0,32'h1C000010,1,0,1,32'hDEADBEEF,1));
    tbl.push_back(mk(1,0,0,2,0,0,0,0,0,
                     0,0,32'h1C000010,1,0,0,32'hDEADBEEF,0));
    // write request is refused
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(1,1,1,2,32'h1C000020,1,0,0,0,
                       0,0,32'h1C000010,1,0,0,32'hDEADBEEF,0));
    // pipelined fetches up to full, in-order return
    tbl.push_back(mk(1,1,0,2,32'h1C000000,0,0,0,0,
                     1,0,32'h1C000010,1,0,0,32'hDEADBEEF,0));
    tbl.push_back(mk(1,1,0,2,32'h1C000004,1,0,0,0,
                     0,1,32'h1C000000,2,1,0,32'hDEADBEEF,0));
    tbl.push_back(mk(1,1,0,2,32'h1C000004,1,0,0,0,
                     1,0,32'h1C000000,2,1,0,32'hDEADBEEF,0));
    tbl.push_back(mk(1,1,0,2,32'h1C000008,1,0,0,0,
                     0,1,32'h1C000004,2,1,0,32'hDEADBEEF,0));
    tbl.push_back(mk(1,1,0,2,32'h1C000008,0,0,0,0,
                     0,0,32'h1C000004,2,1,0,32'hDEADBEEF,0));
    tbl.push_back(mk(1,1,0,2,32'h1C000008,0,1,32'h11111111,0,
                     0,0,32'h1C000004,2,1,0,32'hDEADBEEF,0));
    tbl.push_back(mk(1,1,0,2,32'h1C000008,0,1,32'h22222222,0,
                     1,0,32'h1C000004,2,1,1,32'h11111111,0));
    tbl.push_back(mk(1,0,0,2,0,0,0,0,0,
                     0,1,32'h1C000008,2,1,1,32'h22222222,0));
    // arready stalled: AR stable, no accept
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,1,0,2,32'h1C00000C,0,0,0,0,
                       0,1,32'h1C000008,2,1,0,32'h22222222,0));
    tbl.push_back(mk(1,0,0,2,0,1,0,0,0,
                     0,1,32'h1C000008,2,1,0,32'h22222222,0));
    // reset with one outstanding, late beat ignored
    tbl.push_back(mk(0,0,0,2,0,0,0,0,0,
                     0,0,32'h1C000008,2,1,0,32'h22222222,0));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(1,0,0,2,0,0,1,32'h33333333,0, 0,0,0,2,0,0,0,0));

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      resetn = tbl[i].rst; req = tbl[i].req; wr = tbl[i].wr;
      size = tbl[i].sz; addr = tbl[i].addr; arready = tbl[i].ar;
      rvalid = tbl[i].rv; rdata = tbl[i].rd; rresp = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("v%0d addr_ok", i), 32'(addr_ok), 32'(tbl[i].e_aok));
      chk($sformatf("v%0d arvalid", i), 32'(arvalid), 32'(tbl[i].e_arv));
      chk($sformatf("v%0d araddr", i), araddr, tbl[i].e_araddr);
      chk($sformatf("v%0d arsize", i), 32'(arsize), 32'(tbl[i].e_arsz));
      chk($sformatf("v%0d rready", i), 32'(rready), 32'(tbl[i].e_rrdy));
      chk($sformatf("v%0d data_ok", i), 32'(data_ok), 32'(tbl[i].e_dok));
      chk($sformatf("v%0d rdata", i), sram_rdata, tbl[i].e_rdata);
      chk($sformatf("v%0d rd_err", i), 32'(rd_err), 32'(tbl[i].e_err));
    end

    // random traffic against the model; DUT is idle and empty here
    inflight = 0; m_dok = 0; m_err = 0; m_rdata = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      req = ($urandom % 3) != 0;
      wr = ($urandom % 10) == 0;
      size = 2'($urandom_range(0, 2));
      addr = $urandom & 32'hFFFF_FFFC;
      arready = $urandom % 2;
      rvalid = (rq.size() != 0) && (rq[0].t <= cyc);
      rdata = (rq.size() != 0) ? rq[0].d : $urandom;
      rresp = (rq.size() != 0) ? rq[0].r : 2'($urandom);
      @(negedge clk);
      m_aok = req && !wr && (ar_q.size() == 0) && (inflight < MAXO);
      chk("r addr_ok", 32'(addr_ok), 32'(m_aok));
      chk("r arvalid", 32'(arvalid), 32'(ar_q.size() != 0));
      if (ar_q.size() != 0) begin
        chk("r araddr", araddr, ar_q[0].a);
        chk("r arsize", 32'(arsize), {30'd0, ar_q[0].s});
      end
      chk("r rready", 32'(rready), 32'(inflight != 0));
      chk("r data_ok", 32'(data_ok), 32'(m_dok));
      chk("r rd_err", 32'(rd_err), 32'(m_err));
      if (m_dok) chk("r rdata", sram_rdata, m_rdata);

      m_rfire = rvalid && (inflight != 0);
      m_dok = m_rfire;
      m_err = m_rfire && (rresp != 2'b00);
      if (m_rfire) begin
        m_rdata = rq[0].d;
        void'(rq.pop_front());
        inflight--;
      end
      if ((ar_q.size() != 0) && arready) begin
        beat_t b;
        b.d = $urandom;
        b.r = (($urandom % 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        b.t = cyc + 1 + int'($urandom % 6);
        rq.push_back(b);
        void'(ar_q.pop_front());
      end
      if (m_aok) begin
        ar_t e;
        e.a = addr; e.s = size;
        ar_q.push_back(e);
        inflight++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
